multi_dim_array_pipe: RTL and testbench

MULTI_DIM_ARRAY_PIPE -- requirements
Module: multi_dim_array_pipe

---
 rtl/multi_dim_array_pkg.sv | 39 +++
 rtl/mda_skid_buf.sv | 104 ++++++++++
 rtl/multi_dim_array_pipe.sv | 122 ++++++++++++
 tb/tb_multi_dim_array_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_dim_array_pkg.sv
// -----------------------------------------------------------------------------
// multi_dim_array_pkg
//
// Purpose: shared types for multi_dim_array_pipe and its skid buffer.
//   - mode_e       : per-beat transform selector (matches the 2-bit in_mode)
//   - skid_state_e : occupancy state of the 2-entry skid buffer
//   - small helpers that decode which sub-operations a mode implies
//
// No ports (package).
// -----------------------------------------------------------------------------
package multi_dim_array_pkg;

  typedef enum logic [1:0] {
    MODE_PASS          = 2'd0,
    MODE_TRANSPOSE     = 2'd1,
    MODE_REVERSE       = 2'd2,
    MODE_REV_TRANSPOSE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Width of the optional output-transfer counter.
  localparam int COUNT_W = 16;

  // Channel order is reversed for REVERSE and REV_TRANSPOSE.
  function automatic logic mode_reverses(input mode_e m);
    return (m == MODE_REVERSE) || (m == MODE_REV_TRANSPOSE);
  endfunction

  // Row/column swap is requested for TRANSPOSE and REV_TRANSPOSE.
  function automatic logic mode_transposes(input mode_e m);
    return (m == MODE_TRANSPOSE) || (m == MODE_REV_TRANSPOSE);
  endfunction

endpackage

// File: rtl/mda_skid_buf.sv
// -----------------------------------------------------------------------------
// mda_skid_buf
//
// Purpose: 2-entry skid buffer carrying an opaque flat payload with exactly one
// cycle of latency and fully registered handshake outputs.
//
// Storage:
//   head_reg : the entry currently presented on out_data
//   skid_reg : the second entry, filled only when the head is stalled
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   upstream beat valid
//   in_ready   out  registered; high in EMPTY/ONE, low in FULL and in reset
//   in_data    in   [DATA_W-1:0] payload
//   out_valid  out  registered; high in ONE/FULL
//   out_ready  in   downstream accepts
//   out_data   out  [DATA_W-1:0] payload, held stable while stalled
// -----------------------------------------------------------------------------
module mda_skid_buf
  import multi_dim_array_pkg::*;
#(
  parameter int DATA_W = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       state_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] head_reg;
  logic [DATA_W-1:0] skid_reg;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready_reg;
  assign out_xfer = out_valid_reg && out_ready;

  // Single-process FSM. in_ready/out_valid are assigned alongside each state
  // change so they always reflect the state being entered, which keeps both
  // handshake outputs free of any combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= SKID_EMPTY;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      head_reg      <= '0;
      skid_reg      <= '0;
    end else begin
      // Every state except FULL can accept; FULL branches override this.
      in_ready_reg <= 1'b1;
      case (state_reg)
        SKID_EMPTY: begin
          if (in_xfer) begin
            head_reg      <= in_data;
            state_reg     <= SKID_ONE;
            out_valid_reg <= 1'b1;
          end
        end
        SKID_ONE: begin
          if (in_xfer && out_xfer) begin
            // Head leaves and the new beat takes its place: stay in ONE.
            head_reg <= in_data;
          end else if (in_xfer) begin
            // Head is stalled; park the new beat behind it.
            skid_reg     <= in_data;
            state_reg    <= SKID_FULL;
            in_ready_reg <= 1'b0;
          end else if (out_xfer) begin
            state_reg     <= SKID_EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so no input transfer can coincide.
          if (out_xfer) begin
            head_reg  <= skid_reg;
            state_reg <= SKID_ONE;
          end else begin
            in_ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= SKID_EMPTY;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = head_reg;

endmodule

// File: rtl/multi_dim_array_pipe.sv
// -----------------------------------------------------------------------------
// multi_dim_array_pipe
//
// Purpose: applies a per-beat transform to a CHANNELS x ROWS x COLS array of
// WIDTH-bit elements and buffers the result in a 2-entry skid buffer
// (1-cycle latency, 1 beat/cycle sustained, registered handshakes).
//
// Transform (selected by in_mode, sampled with each accepted beat):
//   0 PASS          out[c][r][k] = in[c][r][k]
//   1 TRANSPOSE     out[c][r][k] = in[c][k][r]   (PASS if ROWS != COLS)
//   2 REVERSE       out[c]       = in[CHANNELS-1-c]
//   3 REV_TRANSPOSE REVERSE followed by TRANSPOSE
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_data/in_mode valid
//   in_ready   out  registered, block accepts a beat
//   in_mode    in   [1:0] transform for this beat
//   in_data    in   [ROWS-1:0][COLS-1:0][WIDTH-1:0] x [CHANNELS-1:0]
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts
//   out_data   out  same shape as in_data, transformed
//   out_count  out  [15:0] output-transfer count, wraps; present only when
//                   MULTI_DIM_ARRAY_PIPE_COUNT_EN is defined
// -----------------------------------------------------------------------------
module multi_dim_array_pipe
  import multi_dim_array_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int ROWS     = 3,
  parameter int COLS     = 3,
  parameter int WIDTH    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [1:0]                            in_mode,
  input  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  in_data  [CHANNELS-1:0],
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  out_data [CHANNELS-1:0]
`ifdef MULTI_DIM_ARRAY_PIPE_COUNT_EN
  ,
  output logic [COUNT_W-1:0]                    out_count
`endif
);

  localparam int CH_W   = ROWS * COLS * WIDTH;
  localparam int FLAT_W = CHANNELS * CH_W;

  mode_e mode;
  logic  do_reverse;
  logic  do_transpose;

  assign mode         = mode_e'(in_mode);
  assign do_reverse   = mode_reverses(mode);
  assign do_transpose = mode_transposes(mode);

  // Channel-reordered view, then the row/column-swapped view of it.
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] chan_sel [CHANNELS-1:0];
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] xform    [CHANNELS-1:0];

  logic [FLAT_W-1:0] in_flat;
  logic [FLAT_W-1:0] out_flat;

  // The transform is purely combinational on the input side, so what gets
  // stored is already the final result and a later mode change cannot touch
  // beats that are sitting in the buffer.
  genvar gi, gr, gk;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_sel[gi] = do_reverse ? in_data[CHANNELS-1-gi] : in_data[gi];

      if (ROWS == COLS) begin : g_square
        for (gr = 0; gr < ROWS; gr++) begin : g_row
          for (gk = 0; gk < COLS; gk++) begin : g_col
            assign xform[gi][gr][gk] = do_transpose ? chan_sel[gi][gk][gr]
                                                    : chan_sel[gi][gr][gk];
          end
        end
      end else begin : g_rect
        // A non-square transpose would change the array shape; fall back to PASS.
        assign xform[gi] = chan_sel[gi];
      end

      // Channel gi occupies payload bits [gi*CH_W +: CH_W] on both sides.
      assign in_flat[gi*CH_W +: CH_W] = xform[gi];
      assign out_data[gi]             = out_flat[gi*CH_W +: CH_W];
    end
  endgenerate

  mda_skid_buf #(
    .DATA_W (FLAT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_flat)
  );

`ifdef MULTI_DIM_ARRAY_PIPE_COUNT_EN
  logic [COUNT_W-1:0] count_reg;

  // Free-running wrap at 0xFFFF -> 0x0000 is the natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (out_valid && out_ready) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign out_count = count_reg;
`endif

endmodule

// File: tb/tb_multi_dim_array_pipe.sv
// -----------------------------------------------------------------------------
// tb_multi_dim_array_pipe
//
// Scoreboard bench: stimulus pushes the expected flattened output for every
// accepted beat; a negedge monitor pops and compares on each output transfer.
// WIDTH is raised to 5 so the c*9+r*3+k pattern (max 26) fits unchanged.
// Define MULTI_DIM_ARRAY_PIPE_COUNT_EN to also check out_count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_dim_array_pipe;

  localparam int CH = 3;
  localparam int RW = 3;
  localparam int CL = 3;
  localparam int WD = 5;
  localparam int CH_W   = RW * CL * WD;
  localparam int FLAT_W = CH * CH_W;

  typedef logic [RW-1:0][CL-1:0][WD-1:0] ch_t;
  typedef ch_t arr_t [CH-1:0];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_mode = 2'd0;
  arr_t             in_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  arr_t             out_data;
`ifdef MULTI_DIM_ARRAY_PIPE_COUNT_EN
  logic [15:0]      out_count;
`endif

  int checks = 0;
  int errors = 0;
  int out_xfers = 0;
  logic [FLAT_W-1:0] exp_q [$];

  multi_dim_array_pipe #(
    .CHANNELS (CH), .ROWS (RW), .COLS (CL), .WIDTH (WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef MULTI_DIM_ARRAY_PIPE_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [FLAT_W-1:0] flatten(input arr_t a);
    logic [FLAT_W-1:0] f;
    for (int c = 0; c < CH; c++) f[c*CH_W +: CH_W] = a[c];
    return f;
  endfunction

  // Reference transform written directly from the mode definitions.
  function automatic logic [FLAT_W-1:0] expect_flat(input logic [1:0] m, input arr_t a);
    arr_t o;
    int sc, sr, sk;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < RW; r++)
        for (int k = 0; k < CL; k++) begin
          sc = m[1] ? (CH - 1 - c) : c;
          sr = m[0] ? k : r;
          sk = m[0] ? r : k;
          o[c][r][k] = a[sc][sr][sk];
        end
    return flatten(o);
  endfunction

  task automatic check(input string name, input logic [FLAT_W-1:0] act, input logic [FLAT_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_pattern(input int offset);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < RW; r++)
        for (int k = 0; k < CL; k++)
          in_data[c][r][k] = 5'((c*9 + r*3 + k + offset) % 32);
  endtask

  // Present a beat, wait (bounded) for in_ready, push the expectation and
  // return #1 after the accepting edge. in_valid is left asserted.
  task automatic send(input logic [1:0] m, input bit push, output int stalls);
    int n = 0;
    in_mode  = m;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    stalls = n;
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    if (push) exp_q.push_back(expect_flat(m, in_data));
    @(posedge clk); #1;
  endtask

  // Monitor: every output transfer pops one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_xfers++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat actual=%h required=none", flatten(out_data));
      end else begin
        check("out_beat", flatten(out_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, total_stalls, base_xfers;
    logic [FLAT_W-1:0] held;
    set_pattern(0);

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", FLAT_W'(out_valid), '0);
    check("rst_out_data", flatten(out_data), '0);
    check("rst_in_ready", FLAT_W'(in_ready), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_release", FLAT_W'(in_ready), FLAT_W'(1));

    // PASS with out_ready high: one-cycle out_valid pulse.
    out_ready = 1'b1;
    send(2'd0, 1'b1, st);
    in_valid = 1'b0;
    check("pass_out_valid_hi", FLAT_W'(out_valid), FLAT_W'(1));
    check("pass_data_identity", flatten(out_data), flatten(in_data));
    @(posedge clk); #1;
    check("pass_out_valid_lo", FLAT_W'(out_valid), '0);

    // TRANSPOSE: out[0][0][2] = in[0][2][0] = 6.
    send(2'd1, 1'b1, st);
    in_valid = 1'b0;
    check("transpose_002", FLAT_W'(out_data[0][0][2]), FLAT_W'(6));
    @(posedge clk); #1;
    // REVERSE: out[0][0][0] = in[2][0][0] = 18.
    send(2'd2, 1'b1, st);
    in_valid = 1'b0;
    check("reverse_000", FLAT_W'(out_data[0][0][0]), FLAT_W'(18));
    @(posedge clk); #1;
    // REV_TRANSPOSE: out[0][1][2] = in[2][2][1] = 18+6+1 = 25.
    send(2'd3, 1'b1, st);
    in_valid = 1'b0;
    check("rev_transpose_012", FLAT_W'(out_data[0][1][2]), FLAT_W'(25));
    @(posedge clk); #1;

    // Backpressure: two beats fill the buffer, the third stalls.
    out_ready = 1'b0;
    set_pattern(1);
    send(2'd0, 1'b1, st);
    held = flatten(out_data);
    set_pattern(2);
    send(2'd1, 1'b1, st);
    check("bp_in_ready_full", FLAT_W'(in_ready), '0);
    set_pattern(3);
    in_mode = 2'd2;
    exp_q.push_back(expect_flat(2'd2, in_data));
    repeat (3) @(posedge clk);
    #1;
    check("bp_still_stalled", FLAT_W'(in_ready), '0);
    check("bp_out_data_stable", flatten(out_data), held);
    out_ready = 1'b1;
    st = 0;
    while (!in_ready && st < 20) begin
      @(posedge clk); #1; st++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", FLAT_W'(exp_q.size()), '0);

    // Streaming: 100 back-to-back beats, no stalls, one drain cycle.
    base_xfers = out_xfers;
    total_stalls = 0;
    for (int i = 0; i < 100; i++) begin
      set_pattern(i + 4);
      send(2'(i % 4), 1'b1, st);
      total_stalls += st;
    end
    in_valid = 1'b0;
    check("stream_stalls", FLAT_W'(total_stalls), '0);
    check("stream_xfers_at_last_accept", FLAT_W'(out_xfers - base_xfers), FLAT_W'(99));
    @(posedge clk); #1;
    check("stream_xfers_total", FLAT_W'(out_xfers - base_xfers), FLAT_W'(100));
    check("stream_drained_valid", FLAT_W'(out_valid), '0);
`ifdef MULTI_DIM_ARRAY_PIPE_COUNT_EN
    // 4 single beats + 3 backpressure beats precede the stream.
    check("out_count", FLAT_W'(out_count), FLAT_W'(107));
`endif

    // Mid-flight reset from FULL: buffered beats must vanish.
    out_ready = 1'b0;
    set_pattern(7);
    send(2'd0, 1'b0, st);
    set_pattern(8);
    send(2'd3, 1'b0, st);
    in_valid = 1'b0;
    check("midrst_full", FLAT_W'(in_ready), '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", FLAT_W'(out_valid), '0);
    check("midrst_out_data", flatten(out_data), '0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_stale", FLAT_W'(out_valid), '0);
`ifdef MULTI_DIM_ARRAY_PIPE_COUNT_EN
    check("midrst_count_zero", FLAT_W'(out_count), '0);
`endif
    set_pattern(9);
    send(2'd2, 1'b1, st);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", FLAT_W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
